// File: rtl/eth_manch_rx.sv
// 10BASE-T Manchester receiver: oversampled edge decoder, preamble/SFD hunt, byte assembly.
// Optional build macro ETH_RX_LINK_MON_EN adds the NLP detector and link-integrity timer.
`default_nettype none

module eth_manch_rx #(
  parameter int OVS     = 8,
  parameter int LINK_TO = 12000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sof,
  output logic       rx_eof,
  output logic       rx_err,
  output logic       crs,
  output logic       link_ok,
  output logic       Led_Rx
);

  localparam int CW = $clog2(2*OVS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(2*OVS);
  localparam logic [CW-1:0] MID_MIN = CW'(3*OVS/4);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;
  state_t state, state_nx;

  logic          sync1, sync2, sync3;
  logic [CW-1:0] cnt;
  logic [5:0]    alt;
  logic          prev_bit;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic          byte_seen;
  logic          sof_pend;

  logic edge_det, accept, bit_val, loss, sfd, frame_end;

  assign edge_det = sync2 ^ sync3;
  assign bit_val  = sync2;
  assign accept   = edge_det && ((state == IDLE) || (cnt >= MID_MIN));
  // Flagged one count early so rx_eof lands as cnt reaches 2*OVS.
  assign loss     = (state != IDLE) && !accept && (cnt >= CNT_MAX - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      state <= IDLE;
    end else begin
      sync1 <= Rxd;
      sync2 <= sync1;
      sync3 <= sync2;
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    sfd       = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nx = PREAMBLE;
      end
      PREAMBLE: begin
        if (loss) begin
          state_nx = IDLE;
        end else if (accept && bit_val && prev_bit && (alt >= 6'd6)) begin
          state_nx = DATA;
          sfd      = 1'b1;
        end
      end
      DATA: begin
        if (loss) begin
          state_nx  = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      alt       <= '0;
      prev_bit  <= 1'b0;
      shreg     <= '0;
      bitcnt    <= '0;
      byte_seen <= 1'b0;
      sof_pend  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_sof    <= 1'b0;
      rx_eof    <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= frame_end;
      rx_err   <= frame_end && ((bitcnt != 3'd0) || !byte_seen);

      if (accept)             cnt <= '0;
      else if (cnt < CNT_MAX) cnt <= cnt + 1'b1;

      if (accept) prev_bit <= bit_val;

      if (state == IDLE && accept) begin
        alt <= '0;
      end else if (state == PREAMBLE && accept) begin
        if (bit_val != prev_bit) alt <= (alt == 6'd63) ? alt : alt + 1'b1;
        else                     alt <= '0;
      end

      if (sfd) begin
        bitcnt    <= '0;
        byte_seen <= 1'b0;
        sof_pend  <= 1'b1;
      end else if (state == DATA && accept) begin
        shreg  <= {bit_val, shreg[7:1]};
        bitcnt <= bitcnt + 1'b1;
        if (bitcnt == 3'd7) begin
          rx_data   <= {bit_val, shreg[7:1]};
          rx_valid  <= 1'b1;
          rx_sof    <= sof_pend;
          sof_pend  <= 1'b0;
          byte_seen <= 1'b1;
        end
      end
    end
  end

  assign crs    = (state == DATA) || ((state == PREAMBLE) && (alt >= 6'd4));
  assign Led_Rx = ~crs;

`ifdef ETH_RX_LINK_MON_EN
  localparam int TW = $clog2(LINK_TO + 1);
  localparam logic [CW-1:0] NLP_MIN = CW'(OVS/2);
  localparam logic [CW-1:0] NLP_MAX = CW'(3*OVS/2);

  logic [CW-1:0] high_w;
  logic [CW-1:0] quiet;
  logic          nlp_cand;
  logic [TW-1:0] timer;
  logic          nlp_ok_state, nlp_fire;

  assign nlp_ok_state = (state == IDLE) || ((state == PREAMBLE) && (alt < 6'd4));
  assign nlp_fire     = nlp_cand && !edge_det && (quiet == CNT_MAX - 1'b1) && nlp_ok_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_w   <= '0;
      quiet    <= '0;
      nlp_cand <= 1'b0;
      timer    <= '0;
      link_ok  <= 1'b0;
    end else begin
      if (!sync2)                high_w <= '0;
      else if (high_w < CNT_MAX) high_w <= high_w + 1'b1;

      if (edge_det)              quiet <= '0;
      else if (quiet < CNT_MAX)  quiet <= quiet + 1'b1;

      // A falling edge closes the pulse; its width was counted while sync2 was high.
      if (edge_det)                        nlp_cand <= !sync2 && (high_w >= NLP_MIN) && (high_w <= NLP_MAX);
      else if (quiet == CNT_MAX - 1'b1)    nlp_cand <= 1'b0;

      if (nlp_fire || sfd) begin
        link_ok <= 1'b1;
        timer   <= TW'(LINK_TO - 1);
      end else if (timer != '0) begin
        timer <= timer - 1'b1;
      end else begin
        link_ok <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) link_ok <= 1'b0;
    else        link_ok <= 1'b1;
  end
`endif

endmodule

`default_nettype wire
